// File: rtl/pipe_regfile.sv
// Architectural integer register file (32 x REG_SZ, x0 hardwired to zero) with read/write handshakes.
// Latency: read data and reg_rack registered on the sampling edge; write commits on the sampling edge, reg_wack follows.
// Backpressure: each port runs IDLE->ACK->GAP, accepting at most one request per 3 cycles; requests are ignored outside IDLE.
module pipe_regfile #(
   parameter int REG_SZ = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              reg_re,
   input  logic [4:0]        reg_idx,
   output logic              reg_rack,
   output logic [REG_SZ-1:0] reg_in,
   input  logic              reg_we,
   input  logic [4:0]        reg_widx,
   input  logic [REG_SZ-1:0] reg_wdata,
   output logic              reg_wack
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_GAP  = 2'd2
   } hs_state_t;

   hs_state_t rd_state, rd_state_nxt;
   hs_state_t wr_state, wr_state_nxt;

   logic [REG_SZ-1:0] regs [32];
   logic              rd_take;
   logic              wr_commit;
   logic [REG_SZ-1:0] rd_data;

   // Requests are only qualified while the corresponding FSM sits in IDLE.
   assign rd_take   = (rd_state == ST_IDLE) && reg_re;
   assign wr_commit = (wr_state == ST_IDLE) && reg_we;

   // Read FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_state <= ST_IDLE;
      else        rd_state <= rd_state_nxt;
   end

   // Read FSM next state: a taken request walks ACK then GAP before re-arming.
   always_comb begin
      rd_state_nxt = rd_state;
      case (rd_state)
         ST_IDLE: if (reg_re) rd_state_nxt = ST_ACK;
         ST_ACK:  rd_state_nxt = ST_GAP;
         ST_GAP:  rd_state_nxt = ST_IDLE;
         default: rd_state_nxt = ST_IDLE;
      endcase
   end

   // Read FSM output: acknowledge is high for the single ACK cycle.
   always_comb begin
      reg_rack = (rd_state == ST_ACK);
   end

   // Write FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wr_state <= ST_IDLE;
      else        wr_state <= wr_state_nxt;
   end

   // Write FSM next state: mirrors the read side so write-back sees the same handshake.
   always_comb begin
      wr_state_nxt = wr_state;
      case (wr_state)
         ST_IDLE: if (reg_we) wr_state_nxt = ST_ACK;
         ST_ACK:  wr_state_nxt = ST_GAP;
         ST_GAP:  wr_state_nxt = ST_IDLE;
         default: wr_state_nxt = ST_IDLE;
      endcase
   end

   // Write FSM output: acknowledge is high for the single ACK cycle.
   always_comb begin
      reg_wack = (wr_state == ST_ACK);
   end

   // Read data select: x0 is zero, a same-edge write to the same index is forwarded.
   always_comb begin
      rd_data = regs[reg_idx];
      if (reg_idx == 5'd0)
         rd_data = '0;
      else if (wr_commit && (reg_widx == reg_idx))
         rd_data = reg_wdata;
   end

   // Read data register: captured on a taken request and held until the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       reg_in <= '0;
      else if (rd_take) reg_in <= rd_data;
   end

   // Register storage: commit on the accepting edge; writes to x0 are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (wr_commit && (reg_widx != 5'd0)) begin
         regs[reg_widx] <= reg_wdata;
      end
   end

endmodule

// File: tb/tb_pipe_regfile.sv
module tb_pipe_regfile;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         reg_re = 1'b0;
   logic [4:0]   reg_idx = '0;
   logic         reg_rack;
   logic [W-1:0] reg_in;
   logic         reg_we = 1'b0;
   logic [4:0]   reg_widx = '0;
   logic [W-1:0] reg_wdata = '0;
   logic         reg_wack;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: plain architectural register contents.
   logic [W-1:0] model [32];

   pipe_regfile #(.REG_SZ(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .reg_re    (reg_re),
      .reg_idx   (reg_idx),
      .reg_rack  (reg_rack),
      .reg_in    (reg_in),
      .reg_we    (reg_we),
      .reg_widx  (reg_widx),
      .reg_wdata (reg_wdata),
      .reg_wack  (reg_wack)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] model_read(input logic [4:0] idx);
      return (idx == 5'd0) ? '0 : model[idx];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) model[i] = '0;
   endtask

   // Launch an optional read and an optional write on the same edge and observe
   // the ACK cycle and the GAP cycle that follow. Leaves both FSMs re-armed.
   task automatic do_op(input logic re, input logic [4:0] ridx,
                        input logic we, input logic [4:0] widx, input logic [W-1:0] wdata,
                        output logic rack1, output logic rack2,
                        output logic wack1, output logic wack2,
                        output logic [W-1:0] rd1, output logic [W-1:0] rd2);
      @(negedge clk);
      reg_re = re; reg_idx = ridx;
      reg_we = we; reg_widx = widx; reg_wdata = wdata;
      @(posedge clk);
      #1;
      reg_re = 1'b0; reg_we = 1'b0;
      reg_idx = 5'($urandom); reg_widx = 5'($urandom); reg_wdata = $urandom;
      @(negedge clk);
      rack1 = reg_rack; wack1 = reg_wack; rd1 = reg_in;
      @(negedge clk);
      rack2 = reg_rack; wack2 = reg_wack; rd2 = reg_in;
   endtask

   task automatic test_reset();
      logic r1, r2, w1, w2;
      logic [W-1:0] d1, d2;
      rst_n = 1'b0;
      model_clear();
      #2 clk = clk;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++; if (reg_rack !== 1'b0) begin miscompares++; $display("FAIL reset_rack got=%b exp=0", reg_rack); end
      vectors++; if (reg_wack !== 1'b0) begin miscompares++; $display("FAIL reset_wack got=%b exp=0", reg_wack); end
      vectors++; if (reg_in !== '0) begin miscompares++; $display("FAIL reset_in got=%h exp=0", reg_in); end
      rst_n = 1'b1;
      do_op(1'b1, 5'd7, 1'b0, 5'd0, '0, r1, r2, w1, w2, d1, d2);
      vectors++; if (r1 !== 1'b1) begin miscompares++; $display("FAIL reset_read_rack got=%b exp=1", r1); end
      vectors++; if (d1 !== '0) begin miscompares++; $display("FAIL reset_read_x7 got=%h exp=0", d1); end
   endtask

   task automatic test_write_read();
      logic r1, r2, w1, w2;
      logic [W-1:0] d1, d2;
      do_op(1'b0, 5'd0, 1'b1, 5'd5, 32'h12345678, r1, r2, w1, w2, d1, d2);
      model[5] = 32'h12345678;
      vectors++; if ({w1, w2} !== 2'b10) begin miscompares++; $display("FAIL wr_wack_pulse got=%b exp=10", {w1, w2}); end
      vectors++; if ({r1, r2} !== 2'b00) begin miscompares++; $display("FAIL wr_no_rack got=%b exp=00", {r1, r2}); end
      do_op(1'b1, 5'd5, 1'b0, 5'd0, '0, r1, r2, w1, w2, d1, d2);
      vectors++; if ({r1, r2} !== 2'b10) begin miscompares++; $display("FAIL rd_rack_pulse got=%b exp=10", {r1, r2}); end
      vectors++; if (d1 !== 32'h12345678) begin miscompares++; $display("FAIL rd_x5 got=%h exp=12345678", d1); end
      vectors++; if (d2 !== 32'h12345678) begin miscompares++; $display("FAIL rd_x5_hold got=%h exp=12345678", d2); end
   endtask

   task automatic test_x0();
      logic r1, r2, w1, w2;
      logic [W-1:0] d1, d2;
      do_op(1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, r1, r2, w1, w2, d1, d2);
      vectors++; if ({w1, w2} !== 2'b10) begin miscompares++; $display("FAIL x0_wack got=%b exp=10", {w1, w2}); end
      do_op(1'b1, 5'd0, 1'b0, 5'd0, '0, r1, r2, w1, w2, d1, d2);
      vectors++; if (d1 !== '0) begin miscompares++; $display("FAIL x0_read got=%h exp=0", d1); end
      // Same-edge write to x0 must not be forwarded.
      do_op(1'b1, 5'd0, 1'b1, 5'd0, 32'hA5A5A5A5, r1, r2, w1, w2, d1, d2);
      vectors++; if (d1 !== '0) begin miscompares++; $display("FAIL x0_no_bypass got=%h exp=0", d1); end
   endtask

   task automatic test_bypass();
      logic r1, r2, w1, w2;
      logic [W-1:0] d1, d2;
      do_op(1'b0, 5'd0, 1'b1, 5'd9, 32'h11, r1, r2, w1, w2, d1, d2);
      model[9] = 32'h11;
      do_op(1'b1, 5'd9, 1'b1, 5'd9, 32'h22, r1, r2, w1, w2, d1, d2);
      model[9] = 32'h22;
      vectors++; if (d1 !== 32'h22) begin miscompares++; $display("FAIL bypass_data got=%h exp=22", d1); end
      vectors++; if ({r1, w1} !== 2'b11) begin miscompares++; $display("FAIL bypass_acks got=%b exp=11", {r1, w1}); end
      do_op(1'b1, 5'd9, 1'b0, 5'd0, '0, r1, r2, w1, w2, d1, d2);
      vectors++; if (d1 !== 32'h22) begin miscompares++; $display("FAIL bypass_later got=%h exp=22", d1); end
   endtask

   task automatic test_back_to_back();
      logic r1, r2, w1, w2;
      logic [W-1:0] d1, d2;
      logic [3:0] rack_seen;
      do_op(1'b0, 5'd0, 1'b1, 5'd3, 32'h33333333, r1, r2, w1, w2, d1, d2);
      model[3] = 32'h33333333;
      do_op(1'b0, 5'd0, 1'b1, 5'd4, 32'h44444444, r1, r2, w1, w2, d1, d2);
      model[4] = 32'h44444444;
      @(negedge clk);
      reg_re = 1'b1; reg_idx = 5'd3;
      @(negedge clk);                        // ACK of first read
      rack_seen[0] = reg_rack;
      vectors++; if (reg_in !== model_read(5'd3)) begin miscompares++; $display("FAIL b2b_first got=%h exp=%h", reg_in, model_read(5'd3)); end
      reg_idx = 5'd4;
      @(negedge clk);                        // GAP
      rack_seen[1] = reg_rack;
      @(negedge clk);                        // IDLE, reg_re still high
      rack_seen[2] = reg_rack;
      @(negedge clk);                        // ACK of second read
      rack_seen[3] = reg_rack;
      vectors++; if (reg_in !== model_read(5'd4)) begin miscompares++; $display("FAIL b2b_second got=%h exp=%h", reg_in, model_read(5'd4)); end
      reg_re = 1'b0;
      vectors++; if (rack_seen !== 4'b1001) begin miscompares++; $display("FAIL b2b_rack_pattern got=%b exp=1001", rack_seen); end
      @(negedge clk);
      vectors++; if (reg_rack !== 1'b0) begin miscompares++; $display("FAIL b2b_extra_rack got=%b exp=0", reg_rack); end
      @(negedge clk);
   endtask

   task automatic test_random();
      logic r1, r2, w1, w2;
      logic [W-1:0] d1, d2, exp_d;
      logic re, we;
      logic [4:0] ridx, widx;
      logic [W-1:0] wdata;
      for (int n = 0; n < 200; n++) begin
         re = 1'($urandom); we = 1'($urandom);
         ridx = 5'($urandom_range(0, 7)); widx = 5'($urandom_range(0, 7));
         wdata = $urandom;
         exp_d = (re) ? model_read(ridx) : '0;
         if (re && we && ridx != 0 && ridx == widx) exp_d = wdata;
         do_op(re, ridx, we, widx, wdata, r1, r2, w1, w2, d1, d2);
         if (we && widx != 0) model[widx] = wdata;
         vectors++; if ({r1, r2} !== {re, 1'b0}) begin miscompares++; $display("FAIL rand_rack n=%0d got=%b exp=%b", n, {r1, r2}, {re, 1'b0}); end
         vectors++; if ({w1, w2} !== {we, 1'b0}) begin miscompares++; $display("FAIL rand_wack n=%0d got=%b exp=%b", n, {w1, w2}, {we, 1'b0}); end
         if (re) begin
            vectors++; if (d1 !== exp_d) begin miscompares++; $display("FAIL rand_data n=%0d idx=%0d got=%h exp=%h", n, ridx, d1, exp_d); end
            vectors++; if (d2 !== exp_d) begin miscompares++; $display("FAIL rand_hold n=%0d got=%h exp=%h", n, d2, exp_d); end
         end
      end
      // Full sweep reading back every register against the model.
      for (int i = 0; i < 32; i++) begin
         do_op(1'b1, 5'(i), 1'b0, 5'd0, '0, r1, r2, w1, w2, d1, d2);
         vectors++; if (d1 !== model_read(5'(i))) begin miscompares++; $display("FAIL sweep x%0d got=%h exp=%h", i, d1, model_read(5'(i))); end
      end
   endtask

   task automatic test_reset_mid();
      logic r1, r2, w1, w2;
      logic [W-1:0] d1, d2;
      do_op(1'b0, 5'd0, 1'b1, 5'd5, 32'hCAFEF00D, r1, r2, w1, w2, d1, d2);
      model[5] = 32'hCAFEF00D;
      @(negedge clk);
      reg_re = 1'b1; reg_idx = 5'd5;
      reg_we = 1'b1; reg_widx = 5'd6; reg_wdata = 32'h66666666;
      @(posedge clk);
      #1;
      reg_re = 1'b0; reg_we = 1'b0;
      #2;
      vectors++; if ({reg_rack, reg_wack} !== 2'b11) begin miscompares++; $display("FAIL mid_pre_acks got=%b exp=11", {reg_rack, reg_wack}); end
      vectors++; if (reg_in !== 32'hCAFEF00D) begin miscompares++; $display("FAIL mid_pre_data got=%h exp=cafef00d", reg_in); end
      rst_n = 1'b0;
      model_clear();
      #1;
      vectors++; if ({reg_rack, reg_wack} !== 2'b00) begin miscompares++; $display("FAIL mid_acks_drop got=%b exp=00", {reg_rack, reg_wack}); end
      vectors++; if (reg_in !== '0) begin miscompares++; $display("FAIL mid_in_clear got=%h exp=0", reg_in); end
      @(negedge clk);
      rst_n = 1'b1;
      do_op(1'b1, 5'd5, 1'b0, 5'd0, '0, r1, r2, w1, w2, d1, d2);
      vectors++; if ({r1, d1} !== {1'b1, 32'h0}) begin miscompares++; $display("FAIL mid_read_x5 got=%b/%h exp=1/0", r1, d1); end
      do_op(1'b1, 5'd6, 1'b0, 5'd0, '0, r1, r2, w1, w2, d1, d2);
      vectors++; if (d1 !== '0) begin miscompares++; $display("FAIL mid_read_x6 got=%h exp=0", d1); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_x0();
      test_bypass();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
